// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package pipe_pkg;

    // Operand source selects for the EX-stage ALU inputs.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Multiply/divide unit occupancy.
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Tracks the multi-cycle multiply/divide unit as busy for MD_LAT cycles after an accept.
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    output logic mdBusy
);

    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: reload only from IDLE, so the down-counter can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset aborts any window in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mdBusy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall, flush and forwarding control for the five-stage pipeline, plus MD sequencing.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 32,
    parameter int REGW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] rs_ID,
    input  logic [REGW-1:0] rt_ID,
    input  logic            useRs_ID,
    input  logic            useRt_ID,
    input  logic            mdStart_ID,
    input  logic            hiloRd_ID,
    input  logic [REGW-1:0] wreg_EX,
    input  logic            regWr_EX,
    input  logic            memRd_EX,
    input  logic [REGW-1:0] rs_EX,
    input  logic [REGW-1:0] rt_EX,
    input  logic [REGW-1:0] wreg_MEM,
    input  logic            regWr_MEM,
    input  logic [REGW-1:0] wreg_WB,
    input  logic            regWr_WB,
    input  logic            branchTaken_EX,
    output logic            Stall_PC,
    output logic            Stall_IF,
    output logic            Flush_IF,
    output logic            Flush_ID,
    output logic [1:0]      FwdA,
    output logic [1:0]      FwdB,
    output logic            mdBusy
);

    logic load_use;
    logic md_haz;
    logic stall;
    logic accept;

    // Hazard detection; register 0 is hardwired and never creates a dependency.
    always_comb begin
        load_use = memRd_EX && regWr_EX && (wreg_EX != '0) &&
                   ((useRs_ID && (rs_ID == wreg_EX)) || (useRt_ID && (rt_ID == wreg_EX)));
        md_haz   = mdBusy && (hiloRd_ID || mdStart_ID);
        stall    = load_use || md_haz;
        accept   = mdStart_ID && !stall && !branchTaken_EX && !rst;
    end

    // Stall/flush outputs: reset, then taken branch, then stall.
    always_comb begin
        Stall_PC = 1'b0;
        Stall_IF = 1'b0;
        Flush_IF = 1'b0;
        Flush_ID = 1'b0;
        if (rst || branchTaken_EX) begin
            Flush_IF = 1'b1;
            Flush_ID = 1'b1;
        end else if (stall) begin
            Stall_PC = 1'b1;
            Stall_IF = 1'b1;
            Flush_ID = 1'b1;
        end
    end

    // Forwarding select; the younger MEM result wins over WB.
    always_comb begin
        FwdA = FWD_RF;
        FwdB = FWD_RF;
        if (!rst) begin
            if (regWr_MEM && (wreg_MEM != '0) && (wreg_MEM == rs_EX)) begin
                FwdA = FWD_MEM;
            end else if (regWr_WB && (wreg_WB != '0) && (wreg_WB == rs_EX)) begin
                FwdA = FWD_WB;
            end
            if (regWr_MEM && (wreg_MEM != '0) && (wreg_MEM == rt_EX)) begin
                FwdB = FWD_MEM;
            end else if (regWr_WB && (wreg_WB != '0) && (wreg_WB == rt_EX)) begin
                FwdB = FWD_WB;
            end
        end
    end

    md_busy_timer #(
        .MD_LAT(MD_LAT)
    ) u_md_busy_timer (
        .clk   (clk),
        .rst   (rst),
        .accept(accept),
        .mdBusy(mdBusy)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, MD corner sequences, random vs model.
module tb_hazard_ctrl;

    localparam int LAT  = 4;
    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [REGW-1:0] rs_ID, rt_ID, wreg_EX, rs_EX, rt_EX, wreg_MEM, wreg_WB;
    logic            useRs_ID, useRt_ID, mdStart_ID, hiloRd_ID;
    logic            regWr_EX, memRd_EX, regWr_MEM, regWr_WB, branchTaken_EX;
    logic            Stall_PC, Stall_IF, Flush_IF, Flush_ID, mdBusy;
    logic [1:0]      FwdA, FwdB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MD_LAT(LAT),
        .REGW  (REGW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs_ID         (rs_ID),
        .rt_ID         (rt_ID),
        .useRs_ID      (useRs_ID),
        .useRt_ID      (useRt_ID),
        .mdStart_ID    (mdStart_ID),
        .hiloRd_ID     (hiloRd_ID),
        .wreg_EX       (wreg_EX),
        .regWr_EX      (regWr_EX),
        .memRd_EX      (memRd_EX),
        .rs_EX         (rs_EX),
        .rt_EX         (rt_EX),
        .wreg_MEM      (wreg_MEM),
        .regWr_MEM     (regWr_MEM),
        .wreg_WB       (wreg_WB),
        .regWr_WB      (regWr_WB),
        .branchTaken_EX(branchTaken_EX),
        .Stall_PC      (Stall_PC),
        .Stall_IF      (Stall_IF),
        .Flush_IF      (Flush_IF),
        .Flush_ID      (Flush_ID),
        .FwdA          (FwdA),
        .FwdB          (FwdB),
        .mdBusy        (mdBusy)
    );

    typedef struct {
        logic [REGW-1:0] rs_ID, rt_ID, wreg_EX, rs_EX, rt_EX, wreg_MEM, wreg_WB;
        logic            useRs, useRt, mdStart, hilo;
        logic            regWr_EX, memRd_EX, regWr_MEM, regWr_WB, br, rst;
    } in_t;

    typedef struct {
        string      name;
        in_t        i;
        logic [8:0] exp; // {Stall_PC, Stall_IF, Flush_IF, Flush_ID, FwdA, FwdB, mdBusy}
    } vec_t;

    // Reference model: MD window recorded as the edge count of the last accept.
    int cyc   = 0;
    int acc   = 0;
    bit acc_v = 1'b0;

    function automatic bit m_busy();
        return acc_v && (cyc >= acc) && (cyc < acc + LAT);
    endfunction

    function automatic bit m_stall();
        bit lu;
        lu = memRd_EX && regWr_EX && (wreg_EX != 0) &&
             ((useRs_ID && rs_ID == wreg_EX) || (useRt_ID && rt_ID == wreg_EX));
        return lu || (m_busy() && (hiloRd_ID || mdStart_ID));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [REGW-1:0] src);
        if (regWr_MEM && wreg_MEM != 0 && wreg_MEM == src) return 2'b01;
        if (regWr_WB && wreg_WB != 0 && wreg_WB == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [8:0] m_out();
        logic [3:0] sf;
        logic [1:0] fa, fb;
        fa = m_fwd(rs_EX);
        fb = m_fwd(rt_EX);
        if (rst) begin
            sf = 4'b0011; fa = 2'b00; fb = 2'b00;
        end else if (branchTaken_EX) sf = 4'b0011;
        else if (m_stall())          sf = 4'b1101;
        else                         sf = 4'b0000;
        return {sf, fa, fb, m_busy()};
    endfunction

    function automatic in_t zin();
        in_t z;
        z = '{default: '0};
        return z;
    endfunction

    task automatic drive(input in_t v);
        rs_ID = v.rs_ID; rt_ID = v.rt_ID; useRs_ID = v.useRs; useRt_ID = v.useRt;
        mdStart_ID = v.mdStart; hiloRd_ID = v.hilo;
        wreg_EX = v.wreg_EX; regWr_EX = v.regWr_EX; memRd_EX = v.memRd_EX;
        rs_EX = v.rs_EX; rt_EX = v.rt_EX;
        wreg_MEM = v.wreg_MEM; regWr_MEM = v.regWr_MEM;
        wreg_WB = v.wreg_WB; regWr_WB = v.regWr_WB;
        branchTaken_EX = v.br; rst = v.rst;
        #1;
    endtask

    task automatic check(input string nm, input logic [8:0] exp);
        logic [8:0] act;
        act = {Stall_PC, Stall_IF, Flush_IF, Flush_ID, FwdA, FwdB, mdBusy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (stallPC,stallIF,flushIF,flushID,fwdA,fwdB,busy)",
                     nm, act, exp);
        end
    endtask

    // Advance one clock edge, updating the model from the inputs present at the edge.
    task automatic tick();
        bit a;
        a = mdStart_ID && !m_stall() && !branchTaken_EX && !rst;
        @(posedge clk);
        cyc++;
        if (rst) acc_v = 1'b0;
        else if (a) begin
            acc_v = 1'b1;
            acc   = cyc;
        end
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        in_t v;
        vec_t t;

        // Vector table for the combinational paths with the MD unit idle.
        v = zin(); v.memRd_EX = 1; v.regWr_EX = 1; v.wreg_EX = 5; v.useRs = 1; v.rs_ID = 5;
        t.name = "lu_rs";    t.i = v; t.exp = 9'b1101_00_00_0; tbl.push_back(t);
        v.wreg_EX = 0; v.rs_ID = 0;
        t.name = "lu_r0";    t.i = v; t.exp = 9'b0000_00_00_0; tbl.push_back(t);
        v = zin(); v.memRd_EX = 1; v.regWr_EX = 1; v.wreg_EX = 9; v.useRt = 1; v.rt_ID = 9;
        t.name = "lu_rt";    t.i = v; t.exp = 9'b1101_00_00_0; tbl.push_back(t);
        v = zin(); v.memRd_EX = 1; v.regWr_EX = 1; v.wreg_EX = 5; v.rs_ID = 5;
        t.name = "lu_nouse"; t.i = v; t.exp = 9'b0000_00_00_0; tbl.push_back(t);
        v = zin(); v.regWr_EX = 1; v.wreg_EX = 5; v.useRs = 1; v.rs_ID = 5;
        t.name = "alu_dep";  t.i = v; t.exp = 9'b0000_00_00_0; tbl.push_back(t);
        v = zin(); v.rs_EX = 7; v.wreg_MEM = 7; v.regWr_MEM = 1; v.wreg_WB = 7; v.regWr_WB = 1;
        t.name = "fwd_mem";  t.i = v; t.exp = 9'b0000_01_00_0; tbl.push_back(t);
        v.regWr_MEM = 0;
        t.name = "fwd_wb";   t.i = v; t.exp = 9'b0000_10_00_0; tbl.push_back(t);
        v = zin(); v.regWr_MEM = 1; v.regWr_WB = 1;
        t.name = "fwd_r0";   t.i = v; t.exp = 9'b0000_00_00_0; tbl.push_back(t);
        v = zin(); v.rt_EX = 3; v.wreg_MEM = 3; v.regWr_MEM = 1;
        v.rs_EX = 4; v.wreg_WB = 4; v.regWr_WB = 1;
        t.name = "fwd_mix";  t.i = v; t.exp = 9'b0000_10_01_0; tbl.push_back(t);
        v = zin(); v.memRd_EX = 1; v.regWr_EX = 1; v.wreg_EX = 5; v.useRs = 1; v.rs_ID = 5;
        v.br = 1;
        t.name = "br_lu";    t.i = v; t.exp = 9'b0011_00_00_0; tbl.push_back(t);
        v = zin(); v.br = 1;
        t.name = "br";       t.i = v; t.exp = 9'b0011_00_00_0; tbl.push_back(t);
        v = zin();
        t.name = "quiet";    t.i = v; t.exp = 9'b0000_00_00_0; tbl.push_back(t);

        // Reset state.
        v = zin(); v.rst = 1; drive(v);
        tick(); tick();
        check("reset", 9'b0011_00_00_0);
        v.rst = 0; drive(v);

        foreach (tbl[k]) begin
            drive(tbl[k].i);
            check(tbl[k].name, tbl[k].exp);
            tick();
        end

        // MD window with a held HI/LO reader.
        v = zin(); v.mdStart = 1; drive(v);
        check("mdA_start", 9'b0000_00_00_0);
        tick();
        v = zin(); v.hilo = 1; drive(v);
        for (int j = 1; j <= LAT; j++) begin
            check($sformatf("mdA_hold%0d", j), 9'b1101_00_00_1);
            tick();
        end
        check("mdA_release", 9'b0000_00_00_0);

        // Back-to-back MD: the second start waits for IDLE, then opens a new window.
        v = zin(); v.mdStart = 1; drive(v);
        tick();
        for (int j = 1; j <= LAT; j++) begin
            check($sformatf("mdB_stall%0d", j), 9'b1101_00_00_1);
            tick();
        end
        check("mdB_accept2", 9'b0000_00_00_0);
        tick();
        v = zin(); drive(v);
        for (int j = 1; j <= LAT; j++) begin
            check($sformatf("mdB_win%0d", j), 9'b0000_00_00_1);
            tick();
        end
        check("mdB_done", 9'b0000_00_00_0);

        // Reset in the middle of a busy window.
        v = zin(); v.mdStart = 1; drive(v);
        tick();
        v = zin(); drive(v);
        check("mdC_busy1", 9'b0000_00_00_1);
        tick();
        v = zin(); v.rst = 1; v.rs_EX = 7; v.wreg_MEM = 7; v.regWr_MEM = 1; drive(v);
        check("mdC_rst_busy", 9'b0011_00_00_1);
        tick();
        check("mdC_rst_idle", 9'b0011_00_00_0);
        v = zin(); drive(v);
        check("mdC_after", 9'b0000_00_00_0);
        tick();
        check("mdC_stays_idle", 9'b0000_00_00_0);

        // Branch during BUSY, then a start coinciding with a branch.
        v = zin(); v.mdStart = 1; drive(v);
        tick();
        v = zin(); v.br = 1; drive(v);
        check("mdD_br_busy", 9'b0011_00_00_1);
        tick();
        v = zin(); drive(v);
        for (int j = 2; j <= LAT; j++) begin
            check($sformatf("mdD_win%0d", j), 9'b0000_00_00_1);
            tick();
        end
        check("mdD_done", 9'b0000_00_00_0);
        v = zin(); v.mdStart = 1; v.br = 1; drive(v);
        check("mdD_start_br", 9'b0011_00_00_0);
        tick();
        v = zin(); drive(v);
        check("mdD_not_acc", 9'b0000_00_00_0);

        // Randomized stimulus against the reference model.
        for (int n = 0; n < 600; n++) begin
            v.rs_ID = REGW'($urandom_range(0, 3)); v.rt_ID = REGW'($urandom_range(0, 3));
            v.wreg_EX = REGW'($urandom_range(0, 3)); v.rs_EX = REGW'($urandom_range(0, 3));
            v.rt_EX = REGW'($urandom_range(0, 3)); v.wreg_MEM = REGW'($urandom_range(0, 3));
            v.wreg_WB = REGW'($urandom_range(0, 3));
            v.useRs = 1'($urandom); v.useRt = 1'($urandom);
            v.mdStart = ($urandom_range(0, 5) == 0); v.hilo = ($urandom_range(0, 3) == 0);
            v.regWr_EX = 1'($urandom); v.memRd_EX = 1'($urandom);
            v.regWr_MEM = 1'($urandom); v.regWr_WB = 1'($urandom);
            v.br = ($urandom_range(0, 7) == 0); v.rst = ($urandom_range(0, 49) == 0);
            drive(v);
            check($sformatf("rand%0d", n), m_out());
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It watches register usage in ID, EX, MEM and WB and generates the stall, flush and forwarding controls. Its `Flush_ID` output drives the bubble-insert input of the ID/EX pipeline register. It also sequences the shared multi-cycle multiply/divide unit: the unit is tracked as busy for a fixed latency, and any ID instruction that touches HI/LO during that window is held.

## Interface
Parameters:
- `MD_LAT`, default 32: multiply/divide latency in cycles; legal range 2..255.
- `REGW`, default 5: register-index width.

Ports:
- `clk`  in  1: core clock.
- `rst`  in  1: reset, synchronous and active-high.
- `rs_ID`, `rt_ID`  in  REGW: source register indices of the instruction in ID.
- `useRs_ID`, `useRt_ID`  in  1: the ID instruction actually reads rs / rt.
- `mdStart_ID`  in  1: the ID instruction is mult/multu/div/divu.
- `hiloRd_ID`  in  1: the ID instruction reads or writes HI/LO (mfhi, mflo, mthi, mtlo).
- `wreg_EX`  in  REGW: destination register in EX, after the RegDst select.
- `regWr_EX`, `memRd_EX`  in  1: EX writes a register / EX is a load.
- `wreg_MEM`, `regWr_MEM`  in  REGW, 1: destination register and write enable in MEM.
- `wreg_WB`, `regWr_WB`  in  REGW, 1: destination register and write enable in WB.
- `branchTaken_EX`  in  1: branch or jump resolved taken in EX.
- `Stall_PC`, `Stall_IF`  out  1: hold the PC / hold the IF/ID register.
- `Flush_IF`  out  1: clear IF/ID to a nop.
- `Flush_ID`  out  1: zero the ID/EX control fields (bubble).
- `FwdA`, `FwdB`  out  2: operand source for rs / rt in EX.
- `mdBusy`  out  1: the multiply/divide unit is occupied.

## Operation
- Load-use hazard, `loadUse`, is set when all of the following hold:
  - `memRd_EX & regWr_EX`;
  - `wreg_EX != 0`;
  - `(useRs_ID & rs_ID==wreg_EX) | (useRt_ID & rt_ID==wreg_EX)`.
- MD hazard, `mdHaz` = `mdBusy & (hiloRd_ID | mdStart_ID)`.
- `stall` = `loadUse | mdHaz`. When stalling: `Stall_PC=Stall_IF=1`, `Flush_ID=1`, `Flush_IF=0`.
- `branchTaken_EX` has priority over `stall`: `Flush_IF=Flush_ID=1`, `Stall_PC=Stall_IF=0`.
- Quiet cycle (no stall, no branch): all stall and flush outputs are 0.
- MD accept = `mdStart_ID & ~stall & ~branchTaken_EX & ~rst`.
- FSM states:
  - IDLE: on accept, go to BUSY and load `cnt = MD_LAT-1`.
  - BUSY: decrement `cnt` each cycle; when `cnt==0`, return to IDLE. `mdStart_ID` in BUSY is treated as a hazard and is never accepted.
- `mdBusy` = (state == BUSY).
- Counter width is `$clog2(MD_LAT)`; the counter never wraps because the reload happens only in IDLE.
- Forwarding for the rs operand (rt/`FwdB` is identical with `rt_EX`). The ID/EX register already carries `rs_EX`/`rt_EX`; these are additional inputs, `rs_EX`, `rt_EX`  in  REGW.
  - 01 (MEM): `regWr_MEM & wreg_MEM!=0 & wreg_MEM==rs_EX`.
  - 10 (WB): otherwise, `regWr_WB & wreg_WB!=0 & wreg_WB==rs_EX`.
  - 00 (register file): otherwise. 11 is never driven.
  - MEM has priority over WB.
- Register 0 never triggers a hazard or a forward.

## Timing
- `stall`, flush and `Fwd*` outputs are combinational, valid in the same cycle as their inputs; zero latency.
- MD timing: accept is sampled at rising edge k; `mdBusy` is 1 during cycles k+1 .. k+MD_LAT, then 0 at k+MD_LAT+1.
  - A `hiloRd_ID` held in ID proceeds in the first cycle with `mdBusy=0`.
- `rst` high at an edge: the next state is IDLE with `cnt=0`. This aborts any busy window mid-operation, with no partial completion.
- While `rst` is high:
  - `Flush_IF=Flush_ID=1`;
  - `Stall_PC=Stall_IF=0`;
  - `FwdA=FwdB=00`;
  - `mdBusy` follows the state (0 one edge after reset asserts).
- Simultaneous `loadUse` and `mdHaz`: a single stall, with outputs the same as either alone.
- Branch during BUSY: the flush proceeds; the busy window continues undisturbed.
- `mdStart_ID` in the same cycle as `branchTaken_EX`: not accepted.

## Structure
- Package `pipe_pkg` holds:
  - forwarding constants `FWD_RF=2'b00`, `FWD_MEM=2'b01`, `FWD_WB=2'b10`;
  - the FSM state typedef (`MD_IDLE`, `MD_BUSY`).
- Sub-module `md_busy_timer`:
  - contains the FSM and down-counter;
  - ports `clk`, `rst`, `accept`, `mdBusy`; parameter `MD_LAT`.
- The hazard and forwarding logic stays in `hazard_ctrl`.

## Test plan
- Load-use: EX holds `lw $5` (`memRd_EX=1`, `regWr_EX=1`, `wreg_EX=5`); ID has `useRs_ID=1`, `rs_ID=5`. Required: `Stall_PC=Stall_IF=Flush_ID=1`. Repeat with `wreg_EX=0`: no stall.
- Forwarding priority: `rs_EX=7`, MEM `wreg=7` write, WB `wreg=7` write → `FwdA=01`. With the MEM write disabled → `FwdA=10`. With `rs_EX=0` → `FwdA=00`.
- MD window, `MD_LAT=4`: accept at edge 0, then `hiloRd_ID=1` held. Required: `mdBusy` high for cycles 1-4; stall in cycles 1-4; released in cycle 5.
- Branch vs stall: `loadUse` and `branchTaken_EX` together → `Flush_IF=Flush_ID=1`, `Stall_PC=0`.
- Reset mid-MD: assert `rst` at busy cycle 2 → `mdBusy=0` on the next cycle; the flush outputs are 1 while `rst` is high.
- Back-to-back MD: a second `mdStart_ID` during BUSY stalls, then is accepted in the first IDLE cycle, and a new window of `MD_LAT` cycles follows.
